// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared segment constants, digit indices and glyph table for the HH:MM display
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [1:0] DIG_H1 = 2'd3;
    localparam logic [1:0] DIG_H2 = 2'd2;
    localparam logic [1:0] DIG_M1 = 2'd1;
    localparam logic [1:0] DIG_M2 = 2'd0;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h2;
        logic [2:0] m1;
        logic [3:0] m2;
        logic       adjust;
        logic       field_sel;
        logic       colon;
    } snap_t;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 falls back to a dash.
    function automatic logic [6:0] seg_glyph(input logic [3:0] v);
        case (v)
            4'd0:    seg_glyph = 7'h40;
            4'd1:    seg_glyph = 7'h79;
            4'd2:    seg_glyph = 7'h24;
            4'd3:    seg_glyph = 7'h30;
            4'd4:    seg_glyph = 7'h19;
            4'd5:    seg_glyph = 7'h12;
            4'd6:    seg_glyph = 7'h02;
            4'd7:    seg_glyph = 7'h78;
            4'd8:    seg_glyph = 7'h00;
            4'd9:    seg_glyph = 7'h10;
            default: seg_glyph = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// rtl/time_display_scan_if.sv - time digit inputs and multiplexed segment outputs
interface time_display_scan_if;
    logic [1:0] H1;
    logic [3:0] H2;
    logic [2:0] M1;
    logic [3:0] M2;
    logic       adjust;
    logic       field_sel;
    logic       colon;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output H1, H2, M1, M2, adjust, field_sel, colon,
        input  anode, seg, dp
    );

    modport slave (
        input  H1, H2, M1, M2, adjust, field_sel, colon,
        output anode, seg, dp
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-low seven-segment pattern with per-field range check
module bcd_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] value,
    input  logic [3:0] max_value,
    output logic [6:0] pattern
);

    assign pattern = (value > max_value) ? SEG_DASH : seg_glyph(value);

endmodule

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - four-digit multiplexed HH:MM scanner with per-frame snapshot and adjust blink
module time_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                 clk,
    input  logic                 rst,
    time_display_scan_if.slave   disp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] pcnt;
    logic [1:0]    dig;
    logic [BW-1:0] bcnt;
    logic          blink_phase;
    logic          adjust_q;
    snap_t         snap;

    logic          pwrap;
    logic          frame_wrap;
    logic          adjust_rise;
    logic [3:0]    dig_value;
    logic [3:0]    dig_max;
    logic [6:0]    dig_pattern;
    logic          blank;

    assign pwrap       = (pcnt == PW'(SCAN_DIV - 1));
    assign frame_wrap  = pwrap && (dig == DIG_M2);
    assign adjust_rise = disp.adjust && !adjust_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
            dig  <= DIG_H1;
        end else begin
            pcnt <= pwrap ? '0 : pcnt + PW'(1);
            if (pwrap)
                dig <= dig - 2'd1;
        end
    end

    // Latch the whole display state once per frame so a frame never mixes old and new time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap <= '0;
        end else if (frame_wrap) begin
            snap <= '{h1: disp.H1, h2: disp.H2, m1: disp.M1, m2: disp.M2,
                      adjust: disp.adjust, field_sel: disp.field_sel, colon: disp.colon};
        end
    end

    // A fresh adjust entry restarts the blink so the edited field starts out visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adjust_q    <= 1'b0;
            bcnt        <= '0;
            blink_phase <= 1'b0;
        end else begin
            adjust_q <= disp.adjust;
            if (adjust_rise) begin
                bcnt        <= '0;
                blink_phase <= 1'b0;
            end else if (frame_wrap) begin
                if (bcnt == BW'(BLINK_FRAMES - 1)) begin
                    bcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        dig_value = '0;
        dig_max   = '0;
        case (dig)
            DIG_H1: begin
                dig_value = {2'b00, snap.h1};
                dig_max   = 4'd2;
            end
            DIG_H2: begin
                dig_value = snap.h2;
                dig_max   = 4'd9;
            end
            DIG_M1: begin
                dig_value = {1'b0, snap.m1};
                dig_max   = 4'd5;
            end
            default: begin
                dig_value = snap.m2;
                dig_max   = 4'd9;
            end
        endcase
    end

    bcd_to_seg7 u_dec (
        .value     (dig_value),
        .max_value (dig_max),
        .pattern   (dig_pattern)
    );

    assign blank = snap.adjust && blink_phase &&
                   (snap.field_sel ? (dig <= DIG_M1) : (dig >= DIG_H2));

    // Anodes go dark for the first cycle of each slot to hide segment switching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp.anode <= 4'hF;
            disp.seg   <= SEG_BLANK;
            disp.dp    <= 1'b1;
        end else begin
            disp.anode <= (pcnt == '0) ? 4'hF : ~(4'b0001 << dig);
            disp.seg   <= blank ? SEG_BLANK : dig_pattern;
            disp.dp    <= (dig == DIG_H2) ? ~snap.colon : 1'b1;
        end
    end

endmodule

// File: tb/tb_time_display_scan.sv
// tb/tb_time_display_scan.sv - randomized scoreboard bench for time_display_scan
module tb_time_display_scan;

    localparam int D  = 4;
    localparam int BF = 2;
    localparam int F  = 4 * D;

    typedef struct {
        int h1, h2, m1, m2;
        bit adj, fs, col;
    } in_t;

    typedef struct {
        int       edge_no;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    time_display_scan_if dif ();

    time_display_scan #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    in_t  hist[$];
    exp_t q[$];
    in_t  cur;
    int   e;
    int   last_rise;
    int   checks;
    int   failures;
    bit   live;

    function automatic logic [6:0] ref_glyph(int v, int maxv);
        logic [6:0] lit [10];
        lit = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (v > maxv) return 7'h3F;
        return ~lit[v];
    endfunction

    function automatic bit phase_at(int k);
        int c;
        c = k / F - last_rise / F;
        return ((c / BF) % 2) == 1;
    endfunction

    // Expected outputs after edge k+1, from the cycle count and input history alone.
    function automatic exp_t model(int k);
        exp_t r;
        in_t  s;
        int   pc, dg, f, val, mx;
        bit   blank;
        pc = k % D;
        dg = 3 - ((k / D) % 4);
        f  = k / F;
        if (f == 0) s = '{default: 0};
        else        s = hist[f * F];
        case (dg)
            3: begin val = s.h1; mx = 2; end
            2: begin val = s.h2; mx = 9; end
            1: begin val = s.m1; mx = 5; end
            default: begin val = s.m2; mx = 9; end
        endcase
        blank = s.adj && phase_at(k) && (s.fs ? (dg <= 1) : (dg >= 2));
        r.edge_no = k + 1;
        r.anode   = (pc == 0) ? 4'hF : ~(4'b0001 << dg);
        r.seg     = blank ? 7'h7F : ref_glyph(val, mx);
        r.dp      = (dg == 2) ? ~s.col : 1'b1;
        return r;
    endfunction

    task automatic apply(int h1, int h2, int m1, int m2, bit adj, bit fs, bit col);
        cur = '{h1: h1, h2: h2, m1: m1, m2: m2, adj: adj, fs: fs, col: col};
        dif.H1 = 2'(h1);
        dif.H2 = 4'(h2);
        dif.M1 = 3'(m1);
        dif.M2 = 4'(m2);
        dif.adjust    = adj;
        dif.field_sel = fs;
        dif.colon     = col;
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        hist.push_back(cur);
        if (cur.adj && !(e > 1 && hist[e-1].adj)) last_rise = e;
        q.push_back(model(e));
        #1;
    endtask

    task automatic chk_reset(string nm);
        checks++;
        if (dif.anode !== 4'hF || dif.seg !== 7'h7F || dif.dp !== 1'b1) begin
            failures++;
            $display("FAIL %s anode=%h seg=%h dp=%b required anode=F seg=7F dp=1",
                     nm, dif.anode, dif.seg, dif.dp);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        q.delete();
        hist.delete();
        e = 0;
        last_rise = 0;
        rst = 1'b1;
        hist.push_back(cur);
        q.push_back(model(0));
        live = 1'b1;
    endtask

    task automatic random_run(int n);
        for (int i = 0; i < n; i++) begin
            in_t nx;
            nx = cur;
            if ($urandom_range(0, 7) == 0) begin
                nx.h1 = $urandom_range(0, 3);
                nx.h2 = $urandom_range(0, 15);
                nx.m1 = $urandom_range(0, 7);
                nx.m2 = $urandom_range(0, 15);
            end
            if ($urandom_range(0, 31) == 0) nx.adj = !nx.adj;
            if ($urandom_range(0, 31) == 0) nx.fs  = !nx.fs;
            if ($urandom_range(0, 15) == 0) nx.col = !nx.col;
            apply(nx.h1, nx.h2, nx.m1, nx.m2, nx.adj, nx.fs, nx.col);
            tick();
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (live && q.size() > 0 && q[0].edge_no == e) begin
            x = q.pop_front();
            checks++;
            if (dif.anode !== x.anode || dif.seg !== x.seg || dif.dp !== x.dp) begin
                failures++;
                $display("FAIL scan edge=%0d anode=%h seg=%h dp=%b required anode=%h seg=%h dp=%b",
                         x.edge_no, dif.anode, dif.seg, dif.dp, x.anode, x.seg, x.dp);
            end
        end
    end

    initial begin
        int guard;
        checks = 0;
        failures = 0;
        live = 1'b0;
        e = 0;
        last_rise = 0;

        // Reset held with 12:34 applied, then the first frames after release.
        apply(1, 2, 3, 4, 0, 0, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_reset("reset_hold");
        end
        release_reset();
        repeat (2 * F) tick();

        // Change minutes units in the middle of the M1 slot.
        guard = 0;
        while ((e % F) != 2 * D + 1 && guard < F) begin
            tick();
            guard++;
        end
        apply(1, 2, 3, 5, 0, 0, 1);
        repeat (2 * F) tick();

        // Hours blink at 07:45.
        apply(0, 7, 4, 5, 1, 0, 1);
        repeat (7 * F) tick();

        // Re-enter adjust while the blanked phase is active.
        guard = 0;
        while (!phase_at(e) && guard < 200) begin
            tick();
            guard++;
        end
        checks++;
        if (!phase_at(e)) begin
            failures++;
            $display("FAIL reentry_wait blink phase never reached 1 within %0d cycles", guard);
        end
        apply(0, 7, 4, 5, 0, 0, 1);
        tick();
        apply(0, 7, 4, 5, 1, 0, 1);
        repeat (3 * F) tick();

        // Adjust rising edge landing exactly on a blink-counter wrap, minutes selected.
        apply(1, 9, 5, 9, 0, 1, 0);
        repeat (3) tick();
        guard = 0;
        while (!(((e + 1) % F == 0) && ((((e + 1) / F - last_rise / F) % BF) == 0)) && guard < 200) begin
            tick();
            guard++;
        end
        apply(1, 9, 5, 9, 1, 1, 0);
        repeat (5 * F) tick();

        // Out-of-range digits.
        apply(3, 2, 3, 12, 0, 0, 0);
        repeat (2 * F) tick();

        random_run(600);

        // Asynchronous reset in the middle of a slot, between clock edges.
        #3;
        live = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset("async_reset");
        q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_reset("async_hold");
        end
        apply(2, 3, 5, 9, 0, 0, 1);
        release_reset();
        repeat (2 * F) tick();
        random_run(300);

        @(posedge clk);
        e++;
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
